// File: rtl/temp_sched_pkg.sv
// rtl/temp_sched_pkg.sv - shared types and constants for the temperature sample scheduler
package temp_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TRIG = 3'd1,
      WAIT = 3'd2,
      ACC  = 3'd3,
      GAP  = 3'd4
   } schedState_t;

   // Temperature words carry 4 fractional bits: 1 LSB = 1/16 degC.
   localparam int TEMP_FRAC_BITS = 4;
   localparam int TEMP_LSB_DIV   = 1 << TEMP_FRAC_BITS;

   localparam int DEF_TICK_DIV   = 50000;
   localparam int DEF_TIMEOUT_MS = 1000;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with synchronous clear and one-cycle tick
module ms_tick_gen
   import temp_sched_pkg::*;
#(
   parameter int DIV = DEF_TICK_DIV
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Clr,
   output logic Tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
   // The clearing cycle itself counts as the first cycle of the new period.
   localparam logic [CW-1:0] RELOAD = (DIV > 1) ? CW'(1) : '0;

   logic [CW-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt <= '0;
      end else if (Clr) begin
         cnt <= RELOAD;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign Tick = (cnt == LAST);

endmodule

// File: rtl/temp_sample_scheduler.sv
// rtl/temp_sample_scheduler.sv - sequences sensor conversions, averages readings, raises hysteretic alarm
module temp_sample_scheduler
   import temp_sched_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
   parameter int MAX_RETRY  = 3,
   parameter int AVG_LOG2   = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        En,
   input  logic        OneShot,
   input  logic [15:0] IntervalMs,
   input  logic [15:0] AlarmHi,
   input  logic [7:0]  AlarmHyst,
   output logic        SnsStart,
   input  logic        SnsDone,
   input  logic [15:0] SnsData,
   output logic [15:0] TempAvg,
   output logic        TempValid,
   output logic        Alarm,
   output logic        Fault,
   output logic        Busy
);

   localparam int SW    = 16 + AVG_LOG2;
   localparam int NSAMP = 1 << AVG_LOG2;
   localparam int CNTW  = AVG_LOG2 + 1;
   localparam int RW    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);
   localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);
   localparam logic [CNTW-1:0] CNT_FULL   = CNTW'(NSAMP);

   schedState_t state, nextState;

   logic signed [SW-1:0] sum, rawExt, sumNext;
   logic [CNTW-1:0]      sampCnt, cntNext;
   logic [RW-1:0]        retryCnt;
   logic [15:0]          msCount, rawData, avgNext;
   logic                 oneShotLatch, oneShotReq;
   logic                 msTick, tickClr, msTimeout, lastRetry, gapDone;
   logic                 burstFull, publish, alarmNext;
   logic signed [16:0]   avg17, hi17, lo17;

   ms_tick_gen #(.DIV(TICK_DIV)) uTick (
      .Clk  (Clk),
      .Rst  (Rst),
      .Clr  (tickClr),
      .Tick (msTick)
   );

   assign rawExt     = SW'($signed(rawData));
   assign sumNext    = sum + rawExt;
   assign cntNext    = sampCnt + 1'b1;
   assign burstFull  = (cntNext == CNT_FULL);
   assign publish    = (state == ACC) && burstFull;
   assign avgNext    = 16'(sumNext >>> AVG_LOG2);
   assign oneShotReq = OneShot || oneShotLatch;
   assign msTimeout  = msTick && (msCount == TIMEOUT_LAST);
   assign lastRetry  = (retryCnt == RETRY_LAST);
   assign gapDone    = (IntervalMs == 16'd0) || (msTick && (msCount == IntervalMs - 16'd1));

   // 17-bit compare keeps the clear threshold from wrapping near -2048 degC.
   assign avg17 = {avgNext[15], avgNext};
   assign hi17  = {AlarmHi[15], AlarmHi};
   assign lo17  = hi17 - $signed({9'd0, AlarmHyst});

   always_comb begin
      alarmNext = Alarm;
      if (avg17 >= hi17) begin
         alarmNext = 1'b1;
      end else if (avg17 < lo17) begin
         alarmNext = 1'b0;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (En || oneShotReq) nextState = TRIG;
         TRIG: nextState = WAIT;
         WAIT: begin
            if (SnsDone) begin
               nextState = ACC;
            end else if (msTimeout) begin
               nextState = lastRetry ? GAP : TRIG;
            end
         end
         ACC: begin
            if (!burstFull) begin
               nextState = TRIG;
            end else begin
               nextState = En ? GAP : IDLE;
            end
         end
         GAP: begin
            if (oneShotReq) begin
               nextState = TRIG;
            end else if (!En) begin
               nextState = IDLE;
            end else if (gapDone) begin
               nextState = TRIG;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign tickClr = (nextState != state) && ((nextState == WAIT) || (nextState == GAP));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state        <= IDLE;
         sum          <= '0;
         sampCnt      <= '0;
         retryCnt     <= '0;
         msCount      <= '0;
         rawData      <= '0;
         oneShotLatch <= 1'b0;
         TempAvg      <= '0;
         TempValid    <= 1'b0;
         Alarm        <= 1'b0;
         Fault        <= 1'b0;
      end else begin
         state     <= nextState;
         TempValid <= 1'b0;

         // A request arriving in the publish cycle is kept for the next burst.
         if (OneShot) begin
            oneShotLatch <= 1'b1;
         end else if (publish) begin
            oneShotLatch <= 1'b0;
         end

         if (tickClr) begin
            msCount <= '0;
         end else if (msTick && ((state == WAIT) || (state == GAP))) begin
            msCount <= msCount + 16'd1;
         end

         case (state)
            WAIT: begin
               if (SnsDone) begin
                  rawData  <= SnsData;
                  retryCnt <= '0;
               end else if (msTimeout) begin
                  if (lastRetry) begin
                     Fault    <= 1'b1;
                     sum      <= '0;
                     sampCnt  <= '0;
                     retryCnt <= '0;
                  end else begin
                     retryCnt <= retryCnt + 1'b1;
                  end
               end
            end
            ACC: begin
               if (burstFull) begin
                  TempAvg   <= avgNext;
                  TempValid <= 1'b1;
                  Fault     <= 1'b0;
                  Alarm     <= alarmNext;
                  sum       <= '0;
                  sampCnt   <= '0;
               end else begin
                  sum     <= sumNext;
                  sampCnt <= cntNext;
               end
            end
            default: ;
         endcase
      end
   end

   assign SnsStart = (state == TRIG);
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// tb/tb_temp_sample_scheduler.sv - directed self-checking bench for temp_sample_scheduler
module tb_temp_sample_scheduler;

   localparam int TICK_DIV   = 10;
   localparam int TIMEOUT_MS = 5;
   localparam int MAX_RETRY  = 3;
   localparam int AVG_LOG2   = 2;

   logic        Clk, Rst, En, OneShot;
   logic [15:0] IntervalMs, AlarmHi;
   logic [7:0]  AlarmHyst;
   logic        SnsStart, SnsDone;
   logic [15:0] SnsData, TempAvg;
   logic        TempValid, Alarm, Fault, Busy;

   int nChecks = 0;
   int nFails  = 0;
   int cyc = 0;
   int validCount = 0;
   int lastValidCyc = 0;
   int startCyc[$];
   logic [15:0] dataQ[$];
   logic respond = 1'b1;
   int engDelay = 3;
   int pend = 0;
   int baseS, baseV;

   temp_sample_scheduler #(
      .TICK_DIV   (TICK_DIV),
      .TIMEOUT_MS (TIMEOUT_MS),
      .MAX_RETRY  (MAX_RETRY),
      .AVG_LOG2   (AVG_LOG2)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .En         (En),
      .OneShot    (OneShot),
      .IntervalMs (IntervalMs),
      .AlarmHi    (AlarmHi),
      .AlarmHyst  (AlarmHyst),
      .SnsStart   (SnsStart),
      .SnsDone    (SnsDone),
      .SnsData    (SnsData),
      .TempAvg    (TempAvg),
      .TempValid  (TempValid),
      .Alarm      (Alarm),
      .Fault      (Fault),
      .Busy       (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
      end
   endtask

   task automatic waitValid(input int target, input int bound, input string tag);
      int k = 0;
      while (validCount < target && k < bound) begin
         step(1);
         k++;
      end
      checkEq(tag, validCount, target);
   endtask

   task automatic oneShotAvg(input logic [15:0] v, input string tag);
      int target;
      target = validCount + 1;
      for (int i = 0; i < 4; i++) dataQ.push_back(v);
      OneShot = 1'b1;
      step(1);
      OneShot = 1'b0;
      waitValid(target, 300, tag);
      step(3);
   endtask

   // Sensor engine: answers each start after engDelay cycles with the next queued reading.
   initial begin
      SnsDone = 1'b0;
      SnsData = 16'h0;
      forever begin
         @(negedge Clk);
         SnsDone = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               SnsDone = 1'b1;
               if (dataQ.size() > 0) SnsData = dataQ.pop_front();
               else SnsData = 16'h0;
            end
         end
         if (SnsStart && respond) pend = engDelay;
      end
   end

   initial begin
      forever begin
         @(negedge Clk);
         cyc++;
         if (SnsStart) startCyc.push_back(cyc);
         if (TempValid) begin
            validCount++;
            lastValidCyc = cyc;
         end
      end
   end

   initial begin
      Rst = 1'b1; En = 1'b0; OneShot = 1'b0;
      IntervalMs = 16'd0; AlarmHi = 16'h7FFF; AlarmHyst = 8'h00;
      step(4);
      checkEq("rst_start", SnsStart, 1'b0);
      checkEq("rst_valid", TempValid, 1'b0);
      checkEq("rst_avg", TempAvg, 16'h0000);
      checkEq("rst_alarm", Alarm, 1'b0);
      checkEq("rst_fault", Fault, 1'b0);
      checkEq("rst_busy", Busy, 1'b0);
      Rst = 1'b0;
      step(3);
      checkEq("idle_busy", Busy, 1'b0);

      // Periodic sampling: one positive burst then one negative burst.
      dataQ.push_back(16'h0190); dataQ.push_back(16'h0192);
      dataQ.push_back(16'h0194); dataQ.push_back(16'h0196);
      dataQ.push_back(16'hFFFC); dataQ.push_back(16'hFFFD);
      dataQ.push_back(16'hFFFD); dataQ.push_back(16'hFFFD);
      IntervalMs = 16'd2;
      En = 1'b1;
      waitValid(1, 300, "t1_valid");
      checkEq("t1_starts", startCyc.size(), 4);
      checkEq("t1_avg", TempAvg, 16'h0193);
      checkEq("t1_alarm", Alarm, 1'b0);
      begin
         int k = 0;
         while (startCyc.size() < 5 && k < 100) begin step(1); k++; end
         checkEq("t1_restart", startCyc.size(), 5);
         // ACC publishes one cycle before TempValid is seen; ACC to TRIG spans IntervalMs ms.
         if (startCyc.size() >= 5) checkEq("t1_gap", startCyc[4] - lastValidCyc, 2 * TICK_DIV - 1);
      end
      waitValid(2, 300, "t2_valid");
      checkEq("t2_avg", TempAvg, 16'hFFFC);
      En = 1'b0;
      step(25);
      checkEq("t2_idle", Busy, 1'b0);
      checkEq("t2_starts", startCyc.size(), 8);

      // Silent engine: three timeouts, then Fault; a good average clears it.
      respond = 1'b0;
      IntervalMs = 16'd1;
      baseS = startCyc.size();
      En = 1'b1;
      begin
         int k = 0;
         while (Fault !== 1'b1 && k < 400) begin step(1); k++; end
      end
      checkEq("t3_fault", Fault, 1'b1);
      checkEq("t3_starts", startCyc.size() - baseS, 3);
      if (startCyc.size() >= baseS + 3) begin
         checkEq("t3_space1", startCyc[baseS+1] - startCyc[baseS], TIMEOUT_MS * TICK_DIV);
         checkEq("t3_space2", startCyc[baseS+2] - startCyc[baseS+1], TIMEOUT_MS * TICK_DIV);
      end
      checkEq("t3_novalid", validCount, 2);
      respond = 1'b1;
      for (int i = 0; i < 4; i++) dataQ.push_back(16'h0100);
      waitValid(3, 300, "t3_valid");
      checkEq("t3_fault_clr", Fault, 1'b0);
      checkEq("t3_avg", TempAvg, 16'h0100);
      En = 1'b0;
      step(30);

      // One-shot bursts with En low drive the alarm hysteresis.
      AlarmHi = 16'h0200;
      AlarmHyst = 8'h10;
      baseS = startCyc.size();
      baseV = validCount;
      oneShotAvg(16'h0200, "t5_valid");
      step(10);
      checkEq("t5_starts", startCyc.size() - baseS, 4);
      checkEq("t5_onevalid", validCount - baseV, 1);
      checkEq("t5_idle", Busy, 1'b0);
      checkEq("t4_avg200", TempAvg, 16'h0200);
      checkEq("t4_set", Alarm, 1'b1);
      oneShotAvg(16'h01F5, "t4_v1f5");
      checkEq("t4_hold1f5", Alarm, 1'b1);
      oneShotAvg(16'h01F0, "t4_v1f0");
      checkEq("t4_hold1f0", Alarm, 1'b1);
      oneShotAvg(16'h01EF, "t4_v1ef");
      checkEq("t4_clear", Alarm, 1'b0);
      oneShotAvg(16'h01FF, "t4_v1ff");
      checkEq("t4_stay0", Alarm, 1'b0);
      AlarmHi = 16'h8000;
      AlarmHyst = 8'hFF;
      oneShotAvg(16'h8000, "t4_vmin");
      checkEq("t4_avgmin", TempAvg, 16'h8000);
      checkEq("t4_setmin", Alarm, 1'b1);
      AlarmHi = 16'h8010;
      oneShotAvg(16'h8000, "t4_vmin2");
      checkEq("t4_nowrap", Alarm, 1'b1);

      // Reset while waiting on the engine; its late answer must be ignored.
      AlarmHi = 16'h7FFF;
      engDelay = 8;
      dataQ.push_back(16'h0123);
      baseS = startCyc.size();
      baseV = validCount;
      En = 1'b1;
      begin
         int k = 0;
         while (startCyc.size() == baseS && k < 20) begin step(1); k++; end
      end
      step(3);
      checkEq("t6_busy", Busy, 1'b1);
      Rst = 1'b1;
      En = 1'b0;
      step(2);
      Rst = 1'b0;
      step(15);
      checkEq("t6_late_done", dataQ.size(), 0);
      checkEq("t6_novalid", validCount - baseV, 0);
      checkEq("t6_avg", TempAvg, 16'h0000);
      checkEq("t6_alarm", Alarm, 1'b0);
      checkEq("t6_fault", Fault, 1'b0);
      checkEq("t6_busy0", Busy, 1'b0);
      checkEq("t6_start", SnsStart, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
